// File: rtl/joystick_event_queue.sv
// joystick_event_queue: snapshots the player joystick words on every VBlank
// rising edge, diffs them bit by bit against the previous frame, and queues
// one press/release event per changed bit in a first-word-fall-through FIFO.
module joystick_event_queue #(
  parameter int PLAYERS = 6,
  parameter int DEPTH   = 16
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     vblank,
  input  logic [PLAYERS*32-1:0]    joystick,
  input  logic                     rd_en,
  input  logic                     ovf_clr,
  output logic [8:0]               ev_data,
  output logic                     ev_empty,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     overflow,
  output logic                     frame_missed,
  output logic                     scanning
);

  localparam int W  = PLAYERS * 32;
  localparam int IW = $clog2(W);
  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0]  LAST_IDX = 8'(W - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic          vblank_q;
  logic [0:0]    state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [W-1:0]  snap_q, snap_d;
  logic [W-1:0]  prev_q, prev_d;
  logic          overflow_q, overflow_d;
  logic          missed_q, missed_d;
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic [8:0]    mem [DEPTH];

  logic          rise;
  logic [IW-1:0] bit_sel;
  logic          push;
  logic [8:0]    push_data;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign rise      = vblank & ~vblank_q;
  assign bit_sel   = idx_q[IW-1:0];
  assign push_data = {snap_q[bit_sel], idx_q};

  assign ev_count  = wr_q - rd_q;
  assign ev_empty  = (ev_count == '0);
  assign full      = (ev_count == FULL_CNT);
  assign do_pop    = rd_en & ~ev_empty;
  // A push into a full FIFO only lands when a pop frees the slot this cycle.
  assign do_push   = push & (~full | do_pop);

  // Scan FSM: snapshot on VBlank rise, then compare one bit per cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    prev_d  = prev_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          snap_d  = joystick;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      default: begin
        push            = (snap_q[bit_sel] != prev_q[bit_sel]);
        // prev tracks the snapshot even when the event is dropped on overflow.
        prev_d[bit_sel] = snap_q[bit_sel];
        if (idx_q == LAST_IDX) state_d = ST_IDLE;
        else                   idx_d   = idx_q + 8'd1;
      end
    endcase
  end

  // Sticky status flags and FIFO pointers: a set condition beats ovf_clr.
  always_comb begin
    overflow_d = (push & full & ~do_pop) | (overflow_q & ~ovf_clr);
    missed_d   = (rise & (state_q == ST_SCAN)) | (missed_q & ~ovf_clr);
    wr_d       = do_push ? wr_q + 1'b1 : wr_q;
    rd_d       = do_pop  ? rd_q + 1'b1 : rd_q;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      vblank_q   <= 1'b0;
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      snap_q     <= '0;
      prev_q     <= '0;
      overflow_q <= 1'b0;
      missed_q   <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      vblank_q   <= vblank;
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
      missed_q   <= missed_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk_sys) begin
    // NOTE: the storage array is deliberately not reset; the pointers define
    // which entries are valid, and ev_data is forced to zero while empty.
    if (do_push) mem[wr_q[AW-1:0]] <= push_data;
  end

  assign ev_data      = ev_empty ? 9'd0 : mem[rd_q[AW-1:0]];
  assign overflow     = overflow_q;
  assign frame_missed = missed_q;
  assign scanning     = (state_q == ST_SCAN);

endmodule

// File: tb/tb_joystick_event_queue.sv
// Self-checking bench for joystick_event_queue: a frame-level reference model
// pushes expected events into a scoreboard queue at each VBlank rise, and a
// monitor pops and compares whenever the bench reads a non-empty FIFO.
module tb_joystick_event_queue;

  localparam int PLAYERS = 6;
  localparam int DEPTH   = 16;
  localparam int W       = PLAYERS * 32;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          vblank;
  logic [W-1:0]  joystick;
  logic          rd_en;
  logic          ovf_clr;
  logic [8:0]    ev_data;
  logic          ev_empty;
  logic [4:0]    ev_count;
  logic          overflow;
  logic          frame_missed;
  logic          scanning;

  int            n_vec  = 0;
  int            n_fail = 0;
  logic [8:0]    exp_q[$];
  logic [W-1:0]  m_prev;

  joystick_event_queue #(.PLAYERS(PLAYERS), .DEPTH(DEPTH)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .vblank       (vblank),
    .joystick     (joystick),
    .rd_en        (rd_en),
    .ovf_clr      (ovf_clr),
    .ev_data      (ev_data),
    .ev_empty     (ev_empty),
    .ev_count     (ev_count),
    .overflow     (overflow),
    .frame_missed (frame_missed),
    .scanning     (scanning)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must match the oldest expected event.
  always @(negedge clk_sys) begin
    if (!reset && rd_en && !ev_empty) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL pop_unexpected: got %0h, expected no event", ev_data);
      end else begin
        check("pop_data", ev_data, exp_q.pop_front());
      end
    end
  end

  // Reference model: one event per changed bit in ascending index order.
  // With allow_drop the bench does not read during the scan, so events
  // beyond the FIFO capacity are lost.
  task automatic model_frame(input bit allow_drop);
    for (int i = 0; i < W; i++) begin
      if (joystick[i] !== m_prev[i]) begin
        if (!allow_drop || exp_q.size() < DEPTH)
          exp_q.push_back({joystick[i], 8'(i)});
      end
    end
    m_prev = joystick;
  endtask

  task automatic pulse(input bit allow_drop);
    @(posedge clk_sys); #1 vblank = 1'b1;
    model_frame(allow_drop);
    @(posedge clk_sys); #1 vblank = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (scanning && n < 400) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check("scan_done", scanning, 0);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(posedge clk_sys); #1 rd_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rd_en = 1'b1;
    while (!ev_empty && n < 40) begin
      @(posedge clk_sys); #1;
      n++;
    end
    rd_en = 1'b0;
    check("drain_empty", ev_empty, 1);
    check("drain_scoreboard", exp_q.size(), 0);
  endtask

  task automatic clear_flags();
    @(posedge clk_sys); #1 ovf_clr = 1'b1;
    @(posedge clk_sys); #1 ovf_clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_scan;
    int j;
    reset    = 1'b1;
    vblank   = 1'b0;
    joystick = '0;
    rd_en    = 1'b0;
    ovf_clr  = 1'b0;
    m_prev   = '0;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;

    // Reset state.
    check("rst_empty", ev_empty, 1);
    check("rst_count", ev_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_missed", frame_missed, 0);
    check("rst_scanning", scanning, 0);
    check("rst_data", ev_data, 0);

    // Single press then release of player 0 button 4.
    joystick[4] = 1'b1;
    pulse(1'b0);
    wait_idle();
    check("p0b4_count", ev_count, 1);
    check("p0b4_press", ev_data, 9'h104);
    pop_one();
    joystick[4] = 1'b0;
    pulse(1'b0);
    wait_idle();
    check("p0b4_release", ev_data, 9'h004);
    drain();

    // Player 5 buttons 0 and 31, scan length.
    joystick[160] = 1'b1;
    joystick[191] = 1'b1;
    pulse(1'b0);
    n_scan = 0;
    while (scanning && n_scan < 400) begin
      n_scan++;
      @(posedge clk_sys); #1;
    end
    check("scan_cycles", n_scan, 192);
    check("p5_count", ev_count, 2);
    check("p5_first", ev_data, 9'h1A0);
    pop_one();
    check("p5_second", ev_data, 9'h1BF);
    drain();

    // Overflow: 20 presses into a 16-entry FIFO with no reads.
    joystick[19:0] = '1;
    pulse(1'b1);
    wait_idle();
    check("ovf_count", ev_count, 16);
    check("ovf_flag", overflow, 1);
    pulse(1'b1);
    wait_idle();
    check("ovf_nonew_count", ev_count, 16);
    clear_flags();
    check("ovf_cleared", overflow, 0);

    // Full FIFO, pop coinciding with the push of idx 100 (push at rise+102).
    joystick[100] = 1'b1;
    pulse(1'b0);
    repeat (100) @(posedge clk_sys);
    #1 rd_en = 1'b1;
    @(posedge clk_sys); #1 rd_en = 1'b0;
    wait_idle();
    check("full_pp_count", ev_count, 16);
    check("full_pp_ovf", overflow, 0);
    drain();

    // Randomised frames with a few changed bits and random reads mid-scan.
    for (int f = 0; f < 10; f++) begin
      repeat ($urandom_range(1, 6)) begin
        j = $urandom_range(0, W - 1);
        joystick[j] = ~joystick[j];
      end
      pulse(1'b0);
      for (int c = 0; c < 400 && scanning; c++) begin
        rd_en = 1'($urandom_range(0, 1));
        @(posedge clk_sys); #1;
      end
      rd_en = 1'b0;
      check("rnd_scan_done", scanning, 0);
      drain();
      check("rnd_ovf", overflow, 0);
      check("rnd_count", ev_count, 0);
    end

    // Rise 50 cycles into a scan is ignored and flagged.
    joystick    = '0;
    joystick[3] = 1'b1;
    joystick[77] = 1'b1;
    joystick[130] = 1'b1;
    pulse(1'b1);
    repeat (48) @(posedge clk_sys);
    #1 vblank = 1'b1;
    @(posedge clk_sys); #1 vblank = 1'b0;
    check("missed_set", frame_missed, 1);
    check("missed_still_scanning", scanning, 1);
    wait_idle();
    drain();
    clear_flags();
    check("missed_cleared", frame_missed, 0);
    check("missed_ovf_cleared", overflow, 0);

    // Reset mid-scan, then held buttons re-report as presses.
    pulse(1'b1);
    repeat (30) @(posedge clk_sys);
    #3 reset = 1'b1;
    exp_q.delete();
    m_prev = '0;
    #1;
    check("midrst_scanning", scanning, 0);
    check("midrst_empty", ev_empty, 1);
    check("midrst_count", ev_count, 0);
    check("midrst_data", ev_data, 0);
    check("midrst_overflow", overflow, 0);
    @(posedge clk_sys); #1 reset = 1'b0;
    pulse(1'b0);
    wait_idle();
    check("rescan_count", ev_count, 3);
    check("rescan_first", ev_data, 9'h103);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
